// File: rtl/seg7_mux_if.sv
// seg7_mux_if: register bus between a host and seg7_mux.
// Signals: strobe, rw, addr, d_in (host -> display), d_out (display -> host).
interface seg7_mux_if;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out;

  modport master (
    output strobe, rw, addr, d_in,
    input  d_out
  );

  modport slave (
    input  strobe, rw, addr, d_in,
    output d_out
  );
endinterface

// File: rtl/seg7_mux.sv
// seg7_mux: multiplexed hex display driver with dots, blanking and PWM brightness.
// Ports: clk, reset (sync, active-high), bus (seg7_mux_if.slave), seg, an (active-low).
// Optional digit blinking is built in when SEG7_MUX_BLINK_EN is defined.
module seg7_mux #(
  parameter int DIGITS    = 8,
  parameter int CNT_BITS  = 16,
  parameter int DUTY_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  seg7_mux_if.slave         bus,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [CNT_BITS-1:0] PMAX = '1;

  logic [CNT_BITS-1:0]  pre;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  data;
  logic [DIGITS-1:0]    dots;
  logic [DIGITS-1:0]    blank;
  logic [DUTY_BITS-1:0] bright;

`ifdef SEG7_MUX_BLINK_EN
  logic [DIGITS-1:0]    blink;
  logic [7:0]           frame;
`endif

  logic        pmax;
  logic        wrap;
  logic        we;
  logic [2:0]  a;
  logic [31:0] rd;
  logic [3:0]  nib;
  logic        dot;
  logic        blk;
  logic        blink_off;
  logic        en;
  logic [6:0]  glyph;

  // Upper address bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^bus.addr[31:3];

  assign pmax = (pre == PMAX);
  assign wrap = pmax && (idx == LAST);
  assign we   = bus.strobe && bus.rw;
  assign a    = bus.addr[2:0];

  // Per-digit selection by the current index.
  always_comb begin
    nib = '0;
    dot = 1'b0;
    blk = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = data[4*i +: 4];
        dot = dots[i];
        blk = blank[i];
      end
    end
  end

`ifdef SEG7_MUX_BLINK_EN
  always_comb begin
    blink_off = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        blink_off = blink[i] && frame[7];
      end
    end
  end
`else
  assign blink_off = 1'b0;
`endif

  // PWM: top bits of the prescaler against the brightness level.
  assign en = !blk && !blink_off &&
              (pre[CNT_BITS-1 -: DUTY_BITS] < bright);

  // Active-low glyphs, bit order g..a.
  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
    endcase
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (a == 3'd0): rd[4*DIGITS-1:0]  = data;
      (a == 3'd1): rd[DIGITS-1:0]    = dots;
      (a == 3'd2): rd[DIGITS-1:0]    = blank;
      (a == 3'd3): rd[DUTY_BITS-1:0] = bright;
`ifdef SEG7_MUX_BLINK_EN
      (a == 3'd4): rd[DIGITS-1:0]    = blink;
`endif
      default: ;
    endcase
  end

  assign bus.d_out = rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      idx    <= '0;
      data   <= '0;
      dots   <= '0;
      blank  <= '0;
      bright <= '1;
`ifdef SEG7_MUX_BLINK_EN
      blink  <= '0;
      frame  <= '0;
`endif
      an     <= '1;
      seg    <= 8'hFF;
    end else begin
      pre <= pre + 1'b1;
      if (pmax) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
`ifdef SEG7_MUX_BLINK_EN
      if (wrap) begin
        frame <= frame + 8'd1;
      end
`endif
      if (we) begin
        unique case (1'b1)
          (a == 3'd0): data   <= bus.d_in[4*DIGITS-1:0];
          (a == 3'd1): dots   <= bus.d_in[DIGITS-1:0];
          (a == 3'd2): blank  <= bus.d_in[DIGITS-1:0];
          (a == 3'd3): bright <= bus.d_in[DUTY_BITS-1:0];
`ifdef SEG7_MUX_BLINK_EN
          (a == 3'd4): blink  <= bus.d_in[DIGITS-1:0];
`endif
          default: ;
        endcase
      end
      an  <= en ? ~(DIGITS'(1) << idx) : '1;
      seg <= en ? {~dot, glyph} : 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_mux.sv
// tb_seg7_mux: directed bench for seg7_mux (DIGITS=4, CNT_BITS=5, DUTY_BITS=4).
// Register vectors from a table, display behaviour from 128-cycle windows.
module tb_seg7_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg;
  logic [3:0] an;

  seg7_mux_if bus();

  seg7_mux #(
    .DIGITS(4),
    .CNT_BITS(5),
    .DUTY_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int lit [4];
  int dark;
  int dark_bad;
  int bad_an;
  int seg_vary;
  int order_bad;
  logic [7:0] seg_seen [4];
  bit seen [4];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          stb;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.strobe = 1'b0;
    bus.rw = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr_opt(input logic [31:0] a, input logic [31:0] d,
                        input bit stb);
    bus.addr = a;
    bus.d_in = d;
    bus.strobe = stb;
    bus.rw = 1'b1;
    tick();
    bus.strobe = 1'b0;
    bus.rw = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_opt(a, d, 1'b1);
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.d_out, exp);
  endtask

  task automatic run_stats(input int n);
    int prev;
    int k;
    logic [3:0] oh;
    prev = -1;
    dark = 0;
    dark_bad = 0;
    bad_an = 0;
    seg_vary = 0;
    order_bad = 0;
    for (int i = 0; i < 4; i++) begin
      lit[i] = 0;
      seen[i] = 1'b0;
      seg_seen[i] = 8'h00;
    end
    for (int c = 0; c < n; c++) begin
      tick();
      k = -1;
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        if (an == ~oh) k = i;
      end
      if (an == 4'hF) begin
        dark++;
        if (seg !== 8'hFF) dark_bad++;
      end else if (k < 0) begin
        bad_an++;
      end else begin
        lit[k]++;
        if (!seen[k]) begin
          seen[k] = 1'b1;
          seg_seen[k] = seg;
        end else if (seg !== seg_seen[k]) begin
          seg_vary++;
        end
        if (prev >= 0 && k != prev && k != (prev + 1) % 4) order_bad++;
        prev = k;
      end
    end
  endtask

  task automatic chk_lit(input string tag, input int e0, input int e1,
                         input int e2, input int e3);
    chk({tag, "_lit0"}, lit[0], e0);
    chk({tag, "_lit1"}, lit[1], e1);
    chk({tag, "_lit2"}, lit[2], e2);
    chk({tag, "_lit3"}, lit[3], e3);
    chk({tag, "_bad_an"}, bad_an, 0);
    chk({tag, "_dark_seg"}, dark_bad, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.strobe = 1'b0;
    bus.rw = 1'b0;
    bus.addr = '0;
    bus.d_in = '0;

    vecs[0]  = '{32'h0, 32'h12345678, 1'b0, 32'h0};
    vecs[1]  = '{32'h0, 32'hFFFFF8A0, 1'b1, 32'h0000F8A0};
    vecs[2]  = '{32'h1, 32'hFFFFFFF4, 1'b1, 32'h4};
    vecs[3]  = '{32'h2, 32'h000000F2, 1'b1, 32'h2};
    vecs[4]  = '{32'h3, 32'h0000001F, 1'b1, 32'hF};
    vecs[5]  = '{32'h3, 32'h00000008, 1'b1, 32'h8};
`ifdef SEG7_MUX_BLINK_EN
    vecs[6]  = '{32'h4, 32'h0000000F, 1'b1, 32'hF};
`else
    vecs[6]  = '{32'h4, 32'h0000000F, 1'b1, 32'h0};
`endif
    vecs[7]  = '{32'h5, 32'h000000AB, 1'b1, 32'h0};
    vecs[8]  = '{32'h7, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[9]  = '{32'h8, 32'h0, 1'b0, 32'h0000F8A0};
    vecs[10] = '{32'h6, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h2, 32'h0, 1'b1, 32'h0};
    vecs[12] = '{32'h3, 32'hF, 1'b1, 32'hF};

    // Reset state
    do_reset();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    rd("rst_data", 0, 32'h0);
    rd("rst_dots", 1, 32'h0);
    rd("rst_blank", 2, 32'h0);
    rd("rst_bright", 3, 32'hF);

    // Slot timing straight out of reset
    repeat (30) tick();
    chk("slot0_end_an", an, 4'b1110);
    chk("slot0_end_seg", seg, 8'hC0);
    tick();
    chk("slot0_dark1", an, 4'hF);
    tick();
    chk("slot0_dark2", an, 4'hF);
    tick();
    chk("slot1_start", an, 4'b1101);

    run_stats(128);
    chk_lit("scan", 30, 30, 30, 30);
    chk("scan_dark", dark, 8);
    chk("scan_order", order_bad, 0);
    chk("scan_segvary", seg_vary, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("scan_seg%0d", i), seg_seen[i], 8'hC0);
    end

    // Register table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      wr_opt(vecs[i].addr, vecs[i].wdata, vecs[i].stb);
      rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rexp);
    end

    // Glyphs and dots
    do_reset();
    wr(0, 32'h0000F8A0);
    wr(1, 32'h4);
    tick();
    run_stats(128);
    chk_lit("glyph", 30, 30, 30, 30);
    chk("glyph_seg0", seg_seen[0], 8'hC0);
    chk("glyph_seg1", seg_seen[1], 8'h88);
    chk("glyph_seg2", seg_seen[2], 8'h00);
    chk("glyph_seg3", seg_seen[3], 8'h8E);
    chk("glyph_segvary", seg_vary, 0);
    rd("glyph_readback", 0, 32'h0000F8A0);

    // Brightness
    wr(3, 32'h0);
    tick();
    run_stats(128);
    chk_lit("bright0", 0, 0, 0, 0);
    chk("bright0_dark", dark, 128);
    wr(3, 32'h8);
    tick();
    run_stats(128);
    chk_lit("bright8", 16, 16, 16, 16);

    // Blanking digit 1
    wr(3, 32'hF);
    wr(2, 32'h2);
    tick();
    run_stats(128);
    chk_lit("blank", 30, 0, 30, 30);

    // Reset beats a simultaneous write
    bus.addr = 32'h3;
    bus.d_in = 32'h5;
    bus.strobe = 1'b1;
    bus.rw = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.strobe = 1'b0;
    bus.rw = 1'b0;
    rd("rstwr_bright", 3, 32'hF);
    chk("rstwr_an", an, 4'hF);
    wr(0, 32'h1234);
    bus.addr = 32'h0;
    bus.d_in = 32'hBEEF;
    bus.strobe = 1'b1;
    bus.rw = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.strobe = 1'b0;
    bus.rw = 1'b0;
    rd("rstwr_data", 0, 32'h0);

`ifdef SEG7_MUX_BLINK_EN
    // Blink digit 0: lit in frames 0..127, dark in 128..255
    do_reset();
    wr(4, 32'h1);
    run_stats(128);
    chk_lit("blink_lo", 30, 30, 30, 30);
    repeat (128 * 140 - 130) tick();
    run_stats(128);
    chk_lit("blink_hi", 0, 30, 30, 30);
    repeat (128 * 260 - 128 * 141) tick();
    run_stats(128);
    chk_lit("blink_wrap", 30, 30, 30, 30);
`else
    do_reset();
    wr(4, 32'hF);
    rd("blink_absent", 4, 32'h0);
    repeat (10) tick();
    run_stats(128);
    chk_lit("noblink", 30, 30, 30, 30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
